// File: rtl/life_engine.sv
// -----------------------------------------------------------------------------
// life_engine
//   Conway's Game of Life (B3/S23) on a 16x16 toroidal board. A generation is
//   computed one row per cycle into a shadow board. It is then committed in a
//   single edge, so the displayed board never shows a half-updated state.
//
// Parameters
//   TICKDIV    free-run generation period is 2^TICKDIV CLK cycles (5..30)
//   GENW       width of the generation counter
//
// Ports
//   CLK        system clock, all state updates on the rising edge
//   RST        synchronous active-high reset, highest priority
//   Seed       initial board, Seed[r][c] = row r, column c, 1 = live
//   Load       copy Seed into the board; aborts any generation in flight
//   Step       request one generation (ignored while Busy)
//   Run        level; request a generation every 2^TICKDIV cycles
//   RedPixels  current board, [row][col]
//   GrnPixels  cells born in the last committed generation
//   Busy       high while a generation is being computed or committed
//   Done       one-cycle pulse in the first cycle a new board is visible
//   Generation committed generations since the last Load/reset (wraps)
//   AllDead    high when the current board has no live cell
// -----------------------------------------------------------------------------
module life_engine #(
    parameter int TICKDIV = 22,
    parameter int GENW    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [15:0][15:0]     Seed,
    input  logic                  Load,
    input  logic                  Step,
    input  logic                  Run,
    output logic [15:0][15:0]     RedPixels,
    output logic [15:0][15:0]     GrnPixels,
    output logic                  Busy,
    output logic                  Done,
    output logic [GENW-1:0]       Generation,
    output logic                  AllDead
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]          state;
    logic [3:0]          row;
    logic [15:0][15:0]   board;
    logic [15:0][15:0]   next_board;
    logic [15:0][15:0]   grn;
    logic [GENW-1:0]     gen;
    logic                done;
    logic [TICKDIV-1:0]  tick_cnt;
    logic                tick;
    logic                start;
    logic [3:0]          row_up;
    logic [3:0]          row_dn;
    logic [15:0]         calc_row;

    // Next state of one row given the rows above and below it. Column
    // neighbours are taken mod 16 by truncating the index to 4 bits.
    function automatic logic [15:0] life_row(input logic [15:0] above,
                                             input logic [15:0] mid,
                                             input logic [15:0] below);
        logic [15:0] res;
        logic [3:0]  n;
        logic [3:0]  cl;
        logic [3:0]  cr;
        res = '0;
        for (int c = 0; c < 16; c++) begin
            cl = 4'(c + 15);
            cr = 4'(c + 1);
            n  = 4'(above[cl]) + 4'(above[c]) + 4'(above[cr])
               + 4'(mid[cl])                  + 4'(mid[cr])
               + 4'(below[cl]) + 4'(below[c]) + 4'(below[cr]);
            res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
        end
        return res;
    endfunction

    // 4-bit arithmetic gives the toroidal row wrap for free.
    assign row_up   = row - 4'd1;
    assign row_dn   = row + 4'd1;
    assign calc_row = life_row(board[row_up], board[row], board[row_dn]);

    // The counter sits at all-ones in the cycle before it wraps; the wrap
    // edge is also the edge that starts the generation.
    assign tick  = Run && (&tick_cnt);
    assign start = (Step || tick) && (state == IDLE) && !Load;

    always_ff @(posedge CLK) begin
        if (RST || !Run) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICKDIV'(1);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, e.g. GrnPixels sees the old board.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            row        <= 4'd0;
            board      <= '0;
            next_board <= '0;
            grn        <= '0;
            gen        <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Load pre-empts everything; a half-built next_board is simply
            // overwritten by the next generation.
            if (Load) begin
                state <= IDLE;
                row   <= 4'd0;
                board <= Seed;
                grn   <= '0;
                gen   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= CALC;
                            row   <= 4'd0;
                        end
                    end
                    CALC: begin
                        next_board[row] <= calc_row;
                        if (row == 4'd15) begin
                            state <= COMMIT;
                        end else begin
                            row <= row + 4'd1;
                        end
                    end
                    COMMIT: begin
                        board <= next_board;
                        grn   <= next_board & ~board;
                        gen   <= gen + GENW'(1);
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign RedPixels  = board;
    assign GrnPixels  = grn;
    assign Busy       = (state != IDLE);
    assign Done       = done;
    assign Generation = gen;
    assign AllDead    = ~|board;

endmodule

// File: tb/tb_life_engine.sv
// -----------------------------------------------------------------------------
// tb_life_engine
//   Directed bench for life_engine. Stimulus pushes the expected committed
//   board, births, generation count and Done cycle into a queue; a monitor
//   per DUT pops and compares whenever Done is seen. Two instances: the
//   main one with a short tick period, and a GENW=2 one for counter wrap.
// -----------------------------------------------------------------------------
module tb_life_engine;

    typedef struct {
        logic [15:0][15:0] red;
        logic [15:0][15:0] grn;
        logic [15:0]       gen;
        int                cyc;
    } exp_t;

    logic              CLK;
    logic              RST;
    logic [15:0][15:0] Seed;
    logic              Load;
    logic              Step;
    logic              Run;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              Busy;
    logic              Done;
    logic [15:0]       Generation;
    logic              AllDead;

    logic [15:0][15:0] g2_seed;
    logic              g2_load;
    logic              g2_step;
    logic              g2_run;
    logic [15:0][15:0] g2_red;
    logic [15:0][15:0] g2_grn;
    logic              g2_busy;
    logic              g2_done;
    logic [1:0]        g2_gen;
    logic              g2_alldead;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t sb2[$];
    exp_t mon_e;
    exp_t mon2_e;

    life_engine #(.TICKDIV(5), .GENW(16)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .Seed       (Seed),
        .Load       (Load),
        .Step       (Step),
        .Run        (Run),
        .RedPixels  (RedPixels),
        .GrnPixels  (GrnPixels),
        .Busy       (Busy),
        .Done       (Done),
        .Generation (Generation),
        .AllDead    (AllDead)
    );

    life_engine #(.TICKDIV(5), .GENW(2)) u_gen2 (
        .CLK        (CLK),
        .RST        (RST),
        .Seed       (g2_seed),
        .Load       (g2_load),
        .Step       (g2_step),
        .Run        (g2_run),
        .RedPixels  (g2_red),
        .GrnPixels  (g2_grn),
        .Busy       (g2_busy),
        .Done       (g2_done),
        .Generation (g2_gen),
        .AllDead    (g2_alldead)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_main(input logic [15:0][15:0] r, input logic [15:0][15:0] g,
                             input logic [15:0] gen, input int c);
        exp_t e;
        e.red = r; e.grn = g; e.gen = gen; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_g2(input logic [15:0][15:0] r, input logic [15:0][15:0] g,
                           input logic [15:0] gen, input int c);
        exp_t e;
        e.red = r; e.grn = g; e.gen = gen; e.cyc = c;
        sb2.push_back(e);
    endtask

    // Monitors: sample on the falling edge, away from state updates.
    always @(negedge CLK) begin
        if (!RST && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done cycle=%0d actual=Done expected=no Done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", 256'(cyc), 256'(mon_e.cyc));
                check("red", 256'(RedPixels), 256'(mon_e.red));
                check("grn", 256'(GrnPixels), 256'(mon_e.grn));
                check("gen", 256'(Generation), 256'(mon_e.gen));
                check("alldead", 256'(AllDead), 256'(mon_e.red == '0));
                check("busy_at_done", 256'(Busy), 256'(0));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && g2_done) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL g2_spurious_done cycle=%0d actual=Done expected=no Done", cyc);
            end else begin
                mon2_e = sb2.pop_front();
                check("g2_done_cycle", 256'(cyc), 256'(mon2_e.cyc));
                check("g2_red", 256'(g2_red), 256'(mon2_e.red));
                check("g2_grn", 256'(g2_grn), 256'(mon2_e.grn));
                check("g2_gen", 256'(g2_gen), 256'(mon2_e.gen[1:0]));
                check("g2_alldead", 256'(g2_alldead), 256'(mon2_e.red == '0));
            end
        end
    end

    task automatic load_main(input logic [15:0][15:0] s);
        @(posedge CLK); #1;
        Seed = s;
        Load = 1'b1;
        @(posedge CLK); #1;
        Load = 1'b0;
    endtask

    // One Step pulse; the start edge is one edge after the drive point and
    // the commit edge 17 edges after that, so Done shows at cyc+18.
    task automatic step_main(input logic [15:0][15:0] r, input logic [15:0][15:0] g,
                             input logic [15:0] gen);
        @(posedge CLK); #1;
        Step = 1'b1;
        push_main(r, g, gen, cyc + 18);
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (20) @(posedge CLK);
    endtask

    task automatic step_g2(input logic [15:0] gen);
        @(posedge CLK); #1;
        g2_step = 1'b1;
        push_g2('0, '0, gen, cyc + 18);
        @(posedge CLK); #1;
        g2_step = 1'b0;
        repeat (20) @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [15:0][15:0] blink_h, blink_v, grn_v, grn_h;
    logic [15:0][15:0] wrap_in, wrap_out, wrap_grn;
    logic [15:0][15:0] block, single;
    int base;

    initial begin
        blink_h = '0; blink_h[7][6] = 1'b1; blink_h[7][7] = 1'b1; blink_h[7][8] = 1'b1;
        blink_v = '0; blink_v[6][7] = 1'b1; blink_v[7][7] = 1'b1; blink_v[8][7] = 1'b1;
        grn_v   = '0; grn_v[6][7]   = 1'b1; grn_v[8][7]   = 1'b1;
        grn_h   = '0; grn_h[7][6]   = 1'b1; grn_h[7][8]   = 1'b1;
        wrap_in  = '0; wrap_in[0][15] = 1'b1; wrap_in[0][0] = 1'b1; wrap_in[0][1] = 1'b1;
        wrap_out = '0; wrap_out[15][0] = 1'b1; wrap_out[0][0] = 1'b1; wrap_out[1][0] = 1'b1;
        wrap_grn = '0; wrap_grn[15][0] = 1'b1; wrap_grn[1][0] = 1'b1;
        block  = '0; block[4][4] = 1'b1; block[4][5] = 1'b1; block[5][4] = 1'b1; block[5][5] = 1'b1;
        single = '0; single[5][5] = 1'b1;

        RST = 1'b1; Seed = blink_h; Load = 1'b0; Step = 1'b0; Run = 1'b0;
        g2_seed = single; g2_load = 1'b0; g2_step = 1'b0; g2_run = 1'b0;

        // Reset, with Load held alongside to show reset wins.
        repeat (2) @(posedge CLK); #1;
        Load = 1'b1; g2_load = 1'b1;
        @(posedge CLK); #1;
        check("rst_red", 256'(RedPixels), 256'(0));
        check("rst_grn", 256'(GrnPixels), 256'(0));
        check("rst_gen", 256'(Generation), 256'(0));
        check("rst_done", 256'(Done), 256'(0));
        check("rst_busy", 256'(Busy), 256'(0));
        check("rst_alldead", 256'(AllDead), 256'(1));
        check("rst_g2_red", 256'(g2_red), 256'(0));
        RST = 1'b0; Load = 1'b0; g2_load = 1'b0;

        // Blinker, with hold-during-CALC probes.
        load_main(blink_h);
        check("load_red", 256'(RedPixels), 256'(blink_h));
        check("load_alldead", 256'(AllDead), 256'(0));
        @(posedge CLK); #1;
        Step = 1'b1;
        push_main(blink_v, grn_v, 16'd1, cyc + 18);
        @(posedge CLK); #1;
        Step = 1'b0;
        check("busy_after_start", 256'(Busy), 256'(1));
        repeat (8) @(posedge CLK); #1;
        check("hold_red_calc", 256'(RedPixels), 256'(blink_h));
        check("hold_gen_calc", 256'(Generation), 256'(0));
        check("hold_done_calc", 256'(Done), 256'(0));
        repeat (12) @(posedge CLK); #1;
        check("idle_after_commit", 256'(Busy), 256'(0));

        // Second generation, plus a Step pulse mid-computation that must
        // not be queued.
        @(posedge CLK); #1;
        Step = 1'b1;
        push_main(blink_h, grn_h, 16'd2, cyc + 18);
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (4) @(posedge CLK); #1;
        Step = 1'b1;
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (25) @(posedge CLK);

        // Toroidal wrap across column 15/0 and row 15/0.
        load_main(wrap_in);
        step_main(wrap_out, wrap_grn, 16'd1);

        // Still life.
        load_main(block);
        step_main(block, '0, 16'd1);
        step_main(block, '0, 16'd2);
        step_main(block, '0, 16'd3);

        // Abort: Load five cycles after Step.
        @(posedge CLK); #1;
        Step = 1'b1;
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (3) @(posedge CLK); #1;
        Seed = blink_h;
        Load = 1'b1;
        @(posedge CLK); #1;
        Load = 1'b0;
        check("abort_busy", 256'(Busy), 256'(0));
        check("abort_red", 256'(RedPixels), 256'(blink_h));
        check("abort_gen", 256'(Generation), 256'(0));
        check("abort_grn", 256'(GrnPixels), 256'(0));
        check("abort_done", 256'(Done), 256'(0));
        repeat (25) @(posedge CLK);

        // Free-run: first start edge 32 edges after Run rises, then every 32.
        @(posedge CLK); #1;
        Run  = 1'b1;
        base = cyc;
        push_main(blink_v, grn_v, 16'd1, base + 49);
        push_main(blink_h, grn_h, 16'd2, base + 81);
        push_main(blink_v, grn_v, 16'd3, base + 113);
        repeat (39) @(posedge CLK); #1;
        Step = 1'b1;
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (29) @(posedge CLK); #1;
        Step = 1'b1;
        @(posedge CLK); #1;
        Step = 1'b0;
        repeat (45) @(posedge CLK); #1;
        Run = 1'b0;
        repeat (25) @(posedge CLK); #1;
        check("freerun_stopped_busy", 256'(Busy), 256'(0));

        // Generation counter wrap with GENW=2; the single cell dies at once.
        @(posedge CLK); #1;
        g2_seed = single;
        g2_load = 1'b1;
        @(posedge CLK); #1;
        g2_load = 1'b0;
        check("g2_load_alldead", 256'(g2_alldead), 256'(0));
        step_g2(16'd1);
        step_g2(16'd2);
        step_g2(16'd3);
        step_g2(16'd0);

        repeat (5) @(posedge CLK); #1;
        check("sb_drained", 256'(sb.size()), 256'(0));
        check("sb2_drained", 256'(sb2.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
